// File: rtl/xif_stream_coproc.sv
// eXtension-interface streaming load/store coprocessor: in-order speculative queue,
// commit/kill tracking per ID, and a single-instruction head FSM driving memory and results.
module xif_stream_coproc #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [XLEN-1:0] issue_rs0_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  output logic            issue_loadstore_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [ID_W-1:0] mem_id_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_result_valid_i,
  input  logic [ID_W-1:0] mem_result_id_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_result_err_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [XLEN-1:0] result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            result_err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);
  localparam logic [2:0] F3CfgLd = 3'd0, F3CfgSt = 3'd1, F3CfgLs = 3'd2;
  localparam logic [2:0] F3LdNx = 3'd3, F3StNx = 3'd4, F3Test = 3'd5;

  typedef enum logic [2:0] {HIdle, HExec, HMemReq, HMemRsp, HResult} head_state_e;

  logic [DEPTH-1:0] ent_vld_q, ent_cmt_q, ent_kil_q;
  logic [2:0]       ent_op_q  [DEPTH];
  logic [4:0]       ent_rd_q  [DEPTH];
  logic [ID_W-1:0]  ent_id_q  [DEPTH];
  logic [XLEN-1:0]  ent_rs0_q [DEPTH];
  logic [XLEN-1:0]  ent_rs1_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;

  head_state_e      state_q, state_d;
  logic [XLEN-1:0]  ld_ptr_q, ld_ptr_d, st_ptr_q, st_ptr_d;
  logic [XLEN-1:0]  res_data_q, res_data_d;
  logic             res_we_q, res_we_d, res_err_q, res_err_d;

  // Memory responses are registered before the FSM looks at them.
  logic             rsp_vld_q, rsp_err_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [XLEN-1:0]  rsp_data_q;

  logic [2:0] dec_f3;
  logic       dec_ours, enq, deq;
  logic       unused_instr;

  assign dec_f3            = issue_instr_i[14:12];
  assign dec_ours          = (issue_instr_i[6:0] == 7'h0B) && (dec_f3 <= F3Test);
  assign issue_accept_o    = dec_ours;
  assign issue_writeback_o = dec_ours && ((dec_f3 == F3LdNx) || (dec_f3 == F3Test));
  assign issue_loadstore_o = dec_ours && ((dec_f3 == F3LdNx) || (dec_f3 == F3StNx));
  assign issue_ready_o     = (count_q != FullCnt);
  assign enq               = issue_valid_i && issue_ready_o && dec_ours;
  assign unused_instr      = ^issue_instr_i[31:15];

  logic [2:0]      head_op;
  logic [ID_W-1:0] head_id;
  logic [XLEN-1:0] head_rs0, head_rs1;
  assign head_op  = ent_op_q[rptr_q];
  assign head_id  = ent_id_q[rptr_q];
  assign head_rs0 = ent_rs0_q[rptr_q];
  assign head_rs1 = ent_rs1_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_vld_q <= '0;
      ent_cmt_q <= '0;
      ent_kil_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_op_q[i]  <= '0;
        ent_rd_q[i]  <= '0;
        ent_id_q[i]  <= '0;
        ent_rs0_q[i] <= '0;
        ent_rs1_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // A kill never overrides a commit, so an executing head cannot be killed.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_vld_q[i] && commit_valid_i && (ent_id_q[i] == commit_id_i)) begin
          if (commit_kill_i) begin
            if (!ent_cmt_q[i]) ent_kil_q[i] <= 1'b1;
          end else if (!ent_kil_q[i]) begin
            ent_cmt_q[i] <= 1'b1;
          end
        end
      end
      if (deq) begin
        ent_vld_q[rptr_q] <= 1'b0;
        rptr_q            <= rptr_q + PtrW'(1);
      end
      if (enq) begin
        ent_vld_q[wptr_q] <= 1'b1;
        ent_cmt_q[wptr_q] <= commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
        ent_kil_q[wptr_q] <= commit_valid_i && commit_kill_i && (commit_id_i == issue_id_i);
        ent_op_q[wptr_q]  <= dec_f3;
        ent_rd_q[wptr_q]  <= issue_instr_i[11:7];
        ent_id_q[wptr_q]  <= issue_id_i;
        ent_rs0_q[wptr_q] <= issue_rs0_i;
        ent_rs1_q[wptr_q] <= issue_rs1_i;
        wptr_q            <= wptr_q + PtrW'(1);
      end
      count_q <= count_q + (PtrW+1)'(enq) - (PtrW+1)'(deq);
    end
  end

  always_comb begin
    state_d    = state_q;
    deq        = 1'b0;
    ld_ptr_d   = ld_ptr_q;
    st_ptr_d   = st_ptr_q;
    res_data_d = res_data_q;
    res_we_d   = res_we_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      HIdle: begin
        if (ent_vld_q[rptr_q]) begin
          if (ent_cmt_q[rptr_q])      state_d = HExec;
          else if (ent_kil_q[rptr_q]) deq     = 1'b1;
        end
      end
      HExec: begin
        res_data_d = '0;
        res_we_d   = 1'b0;
        res_err_d  = 1'b0;
        state_d    = HResult;
        case (head_op)
          F3CfgLd: ld_ptr_d = head_rs0;
          F3CfgSt: st_ptr_d = head_rs0;
          F3CfgLs: begin
            ld_ptr_d = head_rs0;
            st_ptr_d = head_rs1;
          end
          F3Test: begin
            res_data_d = 32'hDEADBEEF;
            res_we_d   = 1'b1;
          end
          F3LdNx, F3StNx: state_d = HMemReq;
          default: ;
        endcase
      end
      HMemReq: if (mem_ready_i) state_d = HMemRsp;
      HMemRsp: begin
        if (rsp_vld_q && (rsp_id_q == head_id)) begin
          state_d   = HResult;
          res_err_d = rsp_err_q;
          if (!rsp_err_q) begin
            if (head_op == F3LdNx) begin
              ld_ptr_d   = ld_ptr_q + XLEN'(STRIDE);
              res_data_d = rsp_data_q;
              res_we_d   = 1'b1;
            end else begin
              st_ptr_d = st_ptr_q + XLEN'(STRIDE);
            end
          end
        end
      end
      HResult: begin
        if (result_ready_i) begin
          deq     = 1'b1;
          state_d = HIdle;
        end
      end
      default: state_d = HIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HIdle;
      ld_ptr_q   <= '0;
      st_ptr_q   <= '0;
      res_data_q <= '0;
      res_we_q   <= 1'b0;
      res_err_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      st_ptr_q   <= st_ptr_d;
      res_data_q <= res_data_d;
      res_we_q   <= res_we_d;
      res_err_q  <= res_err_d;
      rsp_vld_q  <= mem_result_valid_i;
      rsp_err_q  <= mem_result_err_i;
      rsp_id_q   <= mem_result_id_i;
      rsp_data_q <= mem_rdata_i;
    end
  end

  assign mem_valid_o    = (state_q == HMemReq);
  assign mem_id_o       = mem_valid_o ? head_id : '0;
  assign mem_addr_o     = !mem_valid_o ? '0 : (head_op == F3LdNx) ? ld_ptr_q : st_ptr_q;
  assign mem_we_o       = mem_valid_o && (head_op == F3StNx);
  assign mem_wdata_o    = mem_we_o ? head_rs0 : '0;

  assign result_valid_o = (state_q == HResult);
  assign result_id_o    = result_valid_o ? head_id : '0;
  assign result_rd_o    = result_valid_o ? ent_rd_q[rptr_q] : '0;
  assign result_data_o  = result_valid_o ? res_data_q : '0;
  assign result_we_o    = result_valid_o && res_we_q;
  assign result_err_o   = result_valid_o && res_err_q;

endmodule

// File: tb/tb_xif_stream_coproc.sv
// Scoreboard bench for xif_stream_coproc: directed issue/commit vectors push expected results
// and memory requests; independent monitors pop and compare as the DUT presents them.
module tb_xif_stream_coproc;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [3:0]  issue_id_i = '0;
  logic [31:0] issue_rs0_i = '0, issue_rs1_i = '0;
  logic        issue_accept_o, issue_writeback_o, issue_loadstore_o;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b1;
  logic [3:0]  mem_id_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_we_o;
  logic        mem_result_valid_i = 1'b0;
  logic [3:0]  mem_result_id_i = '0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_result_err_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b1;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o, result_err_o;

  xif_stream_coproc #(.DEPTH(4), .ID_W(4), .XLEN(32), .STRIDE(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .issue_loadstore_o(issue_loadstore_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_id_o(mem_id_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_result_valid_i(mem_result_valid_i), .mem_result_id_i(mem_result_id_i),
    .mem_rdata_i(mem_rdata_i), .mem_result_err_i(mem_result_err_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .result_err_o(result_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        err;
    int          cyc;
  } res_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mreq_t;

  res_t  rq[$];
  mreq_t mq[$];
  int    checks = 0, errors = 0, results_seen = 0, cyc = 0;
  logic  err_mode = 1'b0, bogus_mode = 1'b0;

  localparam logic [31:0] LoadMask = 32'hA5A5_0000;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor
  res_t mon_r;
  always @(negedge clk_i) begin
    if (rst_ni && result_valid_o && result_ready_i) begin
      results_seen++;
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual_id=%0d required=none", result_id_o);
      end else begin
        mon_r = rq.pop_front();
        chk("res_id", 32'(result_id_o), 32'(mon_r.id));
        chk("res_rd", 32'(result_rd_o), 32'(mon_r.rd));
        chk("res_data", result_data_o, mon_r.data);
        chk("res_we", 32'(result_we_o), 32'(mon_r.we));
        chk("res_err", 32'(result_err_o), 32'(mon_r.err));
        if (mon_r.cyc >= 0) chk("res_latency", cyc, mon_r.cyc);
      end
    end
  end

  // Memory model and request monitor; optionally precedes each response with a wrong-ID one.
  mreq_t       mon_m;
  int          mem_pend = 0;
  logic [3:0]  pend_id;
  logic [31:0] pend_data;
  logic        pend_err;
  always @(negedge clk_i) begin
    mem_result_valid_i = 1'b0;
    mem_result_err_i   = 1'b0;
    if (!rst_ni) begin
      mem_pend = 0;
    end else begin
      if (mem_pend == 2) begin
        mem_result_valid_i = 1'b1;
        mem_result_id_i    = pend_id + 4'd1;
        mem_rdata_i        = 32'hFFFF_FFFF;
        mem_result_err_i   = 1'b1;
        mem_pend = 1;
      end else if (mem_pend == 1) begin
        mem_result_valid_i = 1'b1;
        mem_result_id_i    = pend_id;
        mem_rdata_i        = pend_data;
        mem_result_err_i   = pend_err;
        mem_pend = 0;
      end
      if (mem_valid_o && mem_ready_i) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem actual_id=%0d addr=%h required=none", mem_id_o, mem_addr_o);
        end else begin
          mon_m = mq.pop_front();
          chk("mem_id", 32'(mem_id_o), 32'(mon_m.id));
          chk("mem_addr", mem_addr_o, mon_m.addr);
          chk("mem_we", 32'(mem_we_o), 32'(mon_m.we));
          chk("mem_wdata", mem_wdata_o, mon_m.wdata);
        end
        pend_id   = mem_id_o;
        pend_data = mem_addr_o ^ LoadMask;
        pend_err  = err_mode;
        mem_pend  = bogus_mode ? 2 : 1;
      end
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'h0B};
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with t = issue cycle.
  task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] rs0,
                       input logic [31:0] rs1, input logic cmt, input logic [2:0] exp_dec,
                       output int t);
    int n = 0;
    issue_valid_i  = 1'b1;
    issue_instr_i  = instr;
    issue_id_i     = id;
    issue_rs0_i    = rs0;
    issue_rs1_i    = rs1;
    commit_valid_i = cmt;
    commit_id_i    = id;
    commit_kill_i  = 1'b0;
    #1;
    chk("issue_decode", 32'({issue_accept_o, issue_writeback_o, issue_loadstore_o}), 32'(exp_dec));
    while (!issue_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=ready_low required=ready_high");
    end
    t = cyc;
    @(negedge clk_i);
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic op(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                    input logic [31:0] rs0, input logic [31:0] rs1, input logic cmt,
                    input logic [31:0] ed, input logic ewe, input logic eerr, input logic lat);
    int   t;
    res_t r;
    logic wb, ls;
    wb = (f3 == 3'd3) || (f3 == 3'd5);
    ls = (f3 == 3'd3) || (f3 == 3'd4);
    issue(enc(f3, rd), id, rs0, rs1, cmt, {1'b1, wb, ls}, t);
    r.id = id; r.rd = rd; r.data = ed; r.we = ewe; r.err = eerr;
    r.cyc = lat ? t + 3 : -1;
    rq.push_back(r);
  endtask

  task automatic expect_mem(input logic [3:0] id, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata);
    mreq_t m;
    m.id = id; m.addr = addr; m.we = we; m.wdata = wdata;
    mq.push_back(m);
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    @(negedge clk_i);
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain actual_pending_results=%0d pending_mem=%0d required=0",
               rq.size(), mq.size());
      rq.delete();
      mq.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int seen;
    repeat (2) @(negedge clk_i);
    chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_result_valid", 32'(result_valid_o), 32'd0);
    chk("rst_accept", 32'(issue_accept_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // TEST with same-cycle commit: T+3 latency
    op(3'd5, 5'd5, 4'd3, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    wait_idle();
    // Foreign opcode and unused funct3 are rejected and produce nothing
    issue(32'h0000_0033, 4'd4, 32'h0, 32'h0, 1'b1, 3'b000, t);
    issue(enc(3'd6, 5'd1), 4'd5, 32'h0, 32'h0, 1'b1, 3'b000, t);

    // Streaming loads, with a wrong-ID response ahead of each real one
    bogus_mode = 1'b1;
    op(3'd0, 5'd0, 4'd0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      expect_mem(4'(k + 1), 32'h1000 + 32'(4 * k), 1'b0, 32'h0);
      op(3'd3, 5'(6 + k), 4'(k + 1), 32'h0, 32'h0, 1'b1,
         (32'h1000 + 32'(4 * k)) ^ LoadMask, 1'b1, 1'b0, 1'b0);
    end
    wait_idle();
    bogus_mode = 1'b0;

    // Fill the queue with uncommitted TESTs, then commit in order
    for (int k = 0; k < 4; k++)
      op(3'd5, 5'(k + 1), 4'(k), 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("full_ready", 32'(issue_ready_o), 32'd0);
    seen = results_seen;
    repeat (6) @(negedge clk_i);
    chk("no_result_uncommitted", results_seen, seen);
    for (int k = 0; k < 4; k++) commit(4'(k), 1'b0);
    wait_idle();

    // Killed store never reaches memory
    op(3'd1, 5'd0, 4'd0, 32'h2000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(enc(3'd4, 5'd0), 4'd1, 32'h11, 32'h0, 1'b0, 3'b101, t);
    commit(4'd1, 1'b1);
    expect_mem(4'd2, 32'h2000, 1'b1, 32'h22);
    op(3'd4, 5'd0, 4'd2, 32'h22, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Store pointer wrap, then load error leaves ld_ptr unchanged
    op(3'd1, 5'd0, 4'd4, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_mem(4'd5, 32'hFFFF_FFFC, 1'b1, 32'hAA);
    op(3'd4, 5'd0, 4'd5, 32'hAA, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_mem(4'd6, 32'h0000_0000, 1'b1, 32'hBB);
    op(3'd4, 5'd0, 4'd6, 32'hBB, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    op(3'd0, 5'd0, 4'd7, 32'h3000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    err_mode = 1'b1;
    expect_mem(4'd8, 32'h3000, 1'b0, 32'h0);
    op(3'd3, 5'd9, 4'd8, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    wait_idle();
    err_mode = 1'b0;
    expect_mem(4'd9, 32'h3000, 1'b0, 32'h0);
    op(3'd3, 5'd10, 4'd9, 32'h0, 32'h0, 1'b1, 32'h3000 ^ LoadMask, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // CFGLS sets both pointers
    op(3'd2, 5'd0, 4'd10, 32'h4000, 32'h5000, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_mem(4'd11, 32'h4000, 1'b0, 32'h0);
    op(3'd3, 5'd11, 4'd11, 32'h0, 32'h0, 1'b1, 32'h4000 ^ LoadMask, 1'b1, 1'b0, 1'b0);
    expect_mem(4'd12, 32'h5000, 1'b1, 32'h77);
    op(3'd4, 5'd0, 4'd12, 32'h77, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Asynchronous reset while a store is stuck in the request phase
    mem_ready_i = 1'b0;
    issue(enc(3'd4, 5'd0), 4'd13, 32'h99, 32'h0, 1'b1, 3'b101, t);
    for (int n = 0; n < 20 && !mem_valid_o; n++) @(negedge clk_i);
    chk("memreq_reached", 32'(mem_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("arst_result_valid", 32'(result_valid_o), 32'd0);
    chk("arst_issue_ready", 32'(issue_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    // ld_ptr cleared by reset; a surviving store would show up as an unexpected request
    expect_mem(4'd14, 32'h0, 1'b0, 32'h0);
    op(3'd3, 5'd12, 4'd14, 32'h0, 32'h0, 1'b1, 32'h0 ^ LoadMask, 1'b1, 1'b0, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
